// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the pipeline register chain.
package pipe_reg_chain_pkg;

    // Ceiling log2 used to size the occupancy counter (n >= 2 in practice).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < n) begin
            p = p << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One stage of the chain: a data register plus its valid bit, updated on the falling edge.
module pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data only moves with a valid source, so a bubble never overwrites a held word.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= src_valid;
            if (src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Bubble-collapsing valid/ready register chain with freeze, flush and occupancy count.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNTW-1:0]  count
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] can_load;
    logic [WIDTH-1:0] d [DEPTH];
    logic             run;
    logic             accept;
    logic             emit;

    assign run = enable & ~flush;

    // can_load[i] = ~v[i] | (v[i] & can_load[i+1]) reduces to ~v[i] | can_load[i+1];
    // a local ripple variable keeps the vector free of self-dependency.
    always_comb begin
        logic rdy;
        rdy      = out_ready;
        can_load = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            can_load[DEPTH-1-k] = ~v[DEPTH-1-k] | rdy;
            rdy                 = can_load[DEPTH-1-k];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             sv;
        logic [WIDTH-1:0] sd;

        if (i == 0) begin : g_head
            assign sv = in_valid;
            assign sd = in_data;
        end else begin : g_link
            assign sv = v[i-1];
            assign sd = d[i-1];
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .clear    (enable & flush),
            .load     (run & can_load[i]),
            .src_valid(sv),
            .src_data (sd),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    assign in_ready  = run & can_load[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign accept    = in_valid & in_ready;
    assign emit      = run & v[DEPTH-1] & out_ready;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (enable) begin
            if (flush) begin
                count <= '0;
            end else if (accept && !emit) begin
                count <= count + 1'b1;
            end else if (emit && !accept) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
